// File: rtl/router_dst_arbiter.sv
// Destination-side read scheduler: round-robin picks one router FIFO per packet and
// merges its header/payload/parity bytes into a single ready/valid stream.
module router_dst_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LEN_W     = 6
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_PORTS-1:0]          valid_out,
    input  logic [NUM_PORTS*DATA_W-1:0]   dout,
    output logic [NUM_PORTS-1:0]          read_enb,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_sop,
    output logic                          m_eop,
    output logic [1:0]                    grant,
    output logic                          busy
);

    localparam int unsigned RemW = LEN_W + 1;

    typedef enum logic [1:0] {StIdle, StHdr, StHdrWait, StBody} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } entry_t;

    state_e             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [RemW-1:0]    rem_q, rem_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         inflight_port_q, inflight_port_d;
    logic               inflight_sop_q, inflight_sop_d;
    logic               inflight_eop_q, inflight_eop_d;

    entry_t             buf_q [2];
    entry_t             buf_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;

    logic [DATA_W-1:0]  port_data [NUM_PORTS];
    logic [DATA_W-1:0]  arr_data;
    logic [RemW-1:0]    hdr_len;
    logic [RemW-1:0]    rem_eff;
    logic [1:0]         rr_sel;
    logic               rr_found;
    logic [2:0]         cand;
    logic               pop;
    logic               credit;
    logic               issue_state;
    logic               issue;
    logic               issue_sop;
    logic               issue_eop;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_data[p] = dout[p*DATA_W +: DATA_W];
        end
    end

    // The byte arriving this cycle belongs to the port that was read last cycle.
    assign arr_data = port_data[inflight_port_q];
    assign hdr_len  = {1'b0, arr_data[DATA_W-1 -: LEN_W]} + RemW'(1);
    assign rem_eff  = (state_q == StHdrWait) ? hdr_len : rem_q;

    assign pop     = m_valid && m_ready;
    assign credit  = ({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});

    // HDR_WAIT may issue the first payload read in the same cycle the header lands.
    assign issue_state = (state_q == StHdr)
                      || (state_q == StBody && rem_q != '0)
                      || (state_q == StHdrWait && inflight_q);
    assign issue     = issue_state && valid_out[grant_q] && credit;
    assign issue_sop = (state_q == StHdr);
    assign issue_eop = (state_q != StHdr) && (rem_eff == RemW'(1));

    always_comb begin
        read_enb = '0;
        if (issue) begin
            read_enb[grant_q] = 1'b1;
        end
    end

    always_comb begin
        rr_sel   = grant_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = {1'b0, grant_q} + 3'(i);
            if (cand >= 3'(NUM_PORTS)) begin
                cand = cand - 3'(NUM_PORTS);
            end
            if (!rr_found && valid_out[cand[1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = cand[1:0];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        busy_d          = busy_q;
        rem_d           = rem_q;
        inflight_d      = issue;
        inflight_port_d = grant_q;
        inflight_sop_d  = issue_sop;
        inflight_eop_d  = issue_eop;
        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d = rr_sel;
                    busy_d  = 1'b1;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (issue) begin
                    state_d = StHdrWait;
                end
            end
            StHdrWait: begin
                if (inflight_q) begin
                    rem_d = issue ? hdr_len - RemW'(1) : hdr_len;
                    if (issue && hdr_len == RemW'(1)) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (issue) begin
                    rem_d = rem_q - RemW'(1);
                    if (rem_q == RemW'(1)) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (inflight_q) begin
            buf_d[wr_ptr_q] = '{data: arr_data, sop: inflight_sop_q, eop: inflight_eop_q};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= StIdle;
            grant_q         <= 2'(NUM_PORTS - 1);
            busy_q          <= 1'b0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_port_q <= '0;
            inflight_sop_q  <= 1'b0;
            inflight_eop_q  <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            occ_q           <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            busy_q          <= busy_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_port_q <= inflight_port_d;
            inflight_sop_q  <= inflight_sop_d;
            inflight_eop_q  <= inflight_eop_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign m_valid = (occ_q != '0);
    assign m_data  = buf_q[rd_ptr_q].data;
    assign m_sop   = buf_q[rd_ptr_q].sop;
    assign m_eop   = buf_q[rd_ptr_q].eop;
    assign grant   = grant_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_router_dst_arbiter.sv
// Bench for router_dst_arbiter: byte-queue FIFO models feed the DUT, a round-robin packet
// model predicts the merged stream, and a monitor scores every accepted output byte.
module tb_router_dst_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [2:0]  valid_out = '0;
    logic [7:0]  dout_r [3];
    logic [23:0] dout;
    logic [2:0]  read_enb;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_sop;
    logic        m_eop;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    assign dout = {dout_r[2], dout_r[1], dout_r[0]};

    router_dst_arbiter #(
        .NUM_PORTS (3),
        .DATA_W    (8),
        .LEN_W     (6)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_out (valid_out),
        .dout      (dout),
        .read_enb  (read_enb),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] fifo_q [3][$];
    logic [7:0] stage_q [3][$];
    int         rd_count [3];
    logic [2:0] hold = '0;
    int         rmode = 0;
    int         last_grant = 2;
    int         n_cmp = 0;
    int         n_mism = 0;

    initial begin
        for (int p = 0; p < 3; p++) begin
            rd_count[p] = 0;
            dout_r[p]   = '0;
        end
    end

    // Router FIFO model: one-cycle read latency, valid_out tracks non-empty unless held off.
    always @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (read_enb[2'(p)] && fifo_q[p].size() != 0) begin
                dout_r[p]   <= fifo_q[p].pop_front();
                rd_count[p] <= rd_count[p] + 1;
            end
            valid_out[2'(p)] <= (fifo_q[p].size() != 0) && !hold[2'(p)];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = !m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mism++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: read-side protocol, output holding, and scoreboard pop on each handshake.
    initial begin
        int         outstanding;
        int         pop;
        logic       stall_prev;
        logic [7:0] pd;
        logic       ps;
        logic       pe;
        exp_t       e;
        outstanding = 0;
        stall_prev  = 1'b0;
        pd = '0;
        ps = 1'b0;
        pe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                outstanding = 0;
                stall_prev  = 1'b0;
            end else begin
                pop = (m_valid && m_ready) ? 1 : 0;
                if (read_enb != '0) begin
                    check("rd_onehot", $countones(read_enb), 1);
                    check("rd_valid", 32'((read_enb & valid_out) != '0), 1);
                    check("rd_credit", 32'((outstanding - pop) < 2), 1);
                end
                if (stall_prev) begin
                    check("hold_valid", 32'(m_valid), 1);
                    check("hold_data", 32'(m_data), 32'(pd));
                    check("hold_sop", 32'(m_sop), 32'(ps));
                    check("hold_eop", 32'(m_eop), 32'(pe));
                end
                if (pop != 0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_mism++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no output at %0t",
                                 m_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(m_data), 32'(e.data));
                        check("out_sop", 32'(m_sop), 32'(e.sop));
                        check("out_eop", 32'(m_eop), 32'(e.eop));
                    end
                end
                outstanding = outstanding + ((read_enb != '0) ? 1 : 0) - pop;
                stall_prev  = m_valid && !m_ready;
                pd = m_data;
                ps = m_sop;
                pe = m_eop;
            end
        end
    end

    task automatic push_byte(input logic [1:0] p, input logic [7:0] b);
        fifo_q[p].push_back(b);
        stage_q[p].push_back(b);
    endtask

    task automatic gen_pkt(input logic [1:0] p, input int len);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        hdr = {6'(len), 2'($urandom)};
        par = hdr;
        push_byte(p, hdr);
        for (int k = 0; k < len; k++) begin
            b   = 8'($urandom);
            par = par ^ b;
            push_byte(p, b);
        end
        push_byte(p, par);
    endtask

    // Reference: whole packets leave in round-robin order over ports holding staged bytes.
    task automatic build_expected();
        bit         found;
        logic [1:0] p;
        logic [1:0] c;
        logic [7:0] h;
        logic [7:0] b;
        int         n;
        found = 1'b1;
        p = '0;
        while (found) begin
            found = 1'b0;
            for (int i = 1; i <= 3; i++) begin
                c = 2'((last_grant + i) % 3);
                if (!found && stage_q[c].size() != 0) begin
                    found = 1'b1;
                    p = c;
                end
            end
            if (found) begin
                last_grant = int'(p);
                h = stage_q[p].pop_front();
                exp_q.push_back('{data: h, sop: 1'b1, eop: 1'b0});
                n = int'(h[7:2]) + 1;
                for (int k = 1; k <= n; k++) begin
                    b = stage_q[p].pop_front();
                    exp_q.push_back('{data: b, sop: 1'b0, eop: (k == n)});
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy || m_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) begin
            n_cmp++;
            n_mism++;
            $display("FAIL drain_%s: %0d bytes still expected after %0d cycles",
                     name, exp_q.size(), cyc);
        end
        repeat (3) @(negedge clk);
        check({"fifo_empty_", name},
              32'(fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size()), 0);
    endtask

    task automatic wait_read(input logic [1:0] p);
        int c;
        c = 0;
        while (!read_enb[p] && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            n_cmp++;
            n_mism++;
            $display("FAIL wait_read: got no read on port %0d, expected one within 200 cycles", p);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("rst_read_enb", 32'(read_enb), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_sop", 32'(m_sop), 0);
        check("rst_m_eop", 32'(m_eop), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant), 2);
        for (int p = 0; p < 3; p++) begin
            fifo_q[p].delete();
            stage_q[p].delete();
        end
        exp_q.delete();
        hold = '0;
        last_grant = 2;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        int base;
        reset_dut();

        // Single port-1 packet streams at one byte per cycle.
        rmode = 0;
        push_byte(2'd1, 8'h0D);
        push_byte(2'd1, 8'hA1);
        push_byte(2'd1, 8'hA2);
        push_byte(2'd1, 8'hA3);
        push_byte(2'd1, 8'h5E);
        build_expected();
        wait_read(2'd1);
        run = 0;
        while (read_enb[1] && run < 100) begin
            run++;
            @(negedge clk);
        end
        check("t1_read_run", 32'(run), 5);
        wait_drain("t1");
        check("t1_grant", 32'(grant), 1);
        check("t1_busy", 32'(busy), 0);

        // Round-robin from a fresh reset, then a second round with ports 0 and 2.
        reset_dut();
        for (int p = 0; p < 3; p++) gen_pkt(2'(p), 1);
        build_expected();
        wait_read(2'd0);
        check("t2_first_port", 32'(read_enb), 32'b001);
        wait_drain("t2a");
        gen_pkt(2'd0, 1);
        gen_pkt(2'd2, 1);
        build_expected();
        wait_drain("t2b");
        check("t2_grant", 32'(grant), 2);

        // Back-pressure toggling every cycle.
        rmode = 1;
        gen_pkt(2'd0, 2);
        build_expected();
        wait_drain("t3");
        rmode = 0;

        // Zero-length packet: header plus parity only.
        base = rd_count[2];
        push_byte(2'd2, 8'h00);
        push_byte(2'd2, 8'h00);
        build_expected();
        wait_read(2'd2);
        check("t4_busy_first", 32'(busy), 1);
        @(negedge clk);
        check("t4_second_read", 32'(read_enb), 32'b100);
        @(negedge clk);
        check("t4_busy_clear", 32'(busy), 0);
        wait_drain("t4");
        check("t4_reads", 32'(rd_count[2] - base), 2);

        // Port 0 source stalls mid-payload while port 1 waits.
        base = rd_count[0];
        gen_pkt(2'd0, 8);
        gen_pkt(2'd1, 1);
        build_expected();
        run = 0;
        while (rd_count[0] < base + 4 && run < 100) begin
            @(negedge clk);
            run++;
        end
        hold[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t5_no_read", 32'(read_enb), 0);
            check("t5_grant", 32'(grant), 0);
        end
        hold[0] = 1'b0;
        wait_drain("t5");

        // Randomised rounds with random back-pressure.
        rmode = 2;
        for (int r = 0; r < 8; r++) begin
            int np;
            bit any;
            any = 1'b0;
            for (int p = 0; p < 3; p++) begin
                np = $urandom_range(0, 2);
                for (int k = 0; k < np; k++) begin
                    gen_pkt(2'(p), $urandom_range(0, 12));
                    any = 1'b1;
                end
            end
            if (!any) gen_pkt(2'(r % 3), 1);
            build_expected();
            wait_drain("rand");
        end
        rmode = 0;

        // Asynchronous reset in the middle of a long packet.
        base = rd_count[0];
        gen_pkt(2'd0, 20);
        build_expected();
        run = 0;
        while (rd_count[0] < base + 6 && run < 100) begin
            @(negedge clk);
            run++;
        end
        reset_dut();
        gen_pkt(2'd1, 3);
        gen_pkt(2'd2, 2);
        build_expected();
        wait_read(2'd1);
        check("t7_first_grant", 32'(read_enb), 32'b010);
        wait_drain("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
